// File: rtl/clkdiv_init_ctrl.sv
// Power-up, reset and CALIB slip sequencer for the CLKDIV divider in the LVDS/SER-DES path.
// All outputs are registered; one down-counter times every state and is reloaded on state entry.
//
// state     | meaning
// WAIT_LOCK | divider held in reset, counting consecutive pll_lock highs
// DIV_RST   | lock stable, clkdiv_resetn held low for RST_CYCLES
// SETTLE    | divider released, waiting for the divided clock to settle
// READY     | divided clock valid, accepting slip requests / auto alignment
// CALIB     | clkdiv_calib high for CALIB_WIDTH cycles (one phase slip)
// GAP       | quiet time after a slip before align_ok is trusted again
`timescale 1ns/1ps
module clkdiv_init_ctrl #(
   parameter int LOCK_STABLE   = 64,
   parameter int RST_CYCLES    = 16,
   parameter int SETTLE_CYCLES = 32,
   parameter int CALIB_WIDTH   = 2,
   parameter int CALIB_GAP     = 16,
   parameter int MAX_CALIB     = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_lock,
   input  logic       auto_align,
   input  logic       align_req,
   input  logic       align_ok,
   output logic       clkdiv_resetn,
   output logic       clkdiv_calib,
   output logic       ready,
   output logic [3:0] calib_count,
   output logic       align_fail,
   output logic       lock_lost
);

   localparam int TW = 8;
   localparam logic [TW-1:0] LOCK_LD   = TW'(LOCK_STABLE - 1);
   localparam logic [TW-1:0] RST_LD    = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] CALW_LD   = TW'(CALIB_WIDTH - 1);
   localparam logic [TW-1:0] GAP_LD    = TW'(CALIB_GAP - 1);
   localparam logic [3:0]    MAXC      = 4'(MAX_CALIB);

   typedef enum logic [2:0] {
      S_WAIT_LOCK,
      S_DIV_RST,
      S_SETTLE,
      S_READY,
      S_CALIB,
      S_GAP
   } state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] tmr, tmr_nxt;
   logic [3:0]    count_nxt;
   logic          fail_nxt;
   logic          lost_nxt;
   logic          tmr_done;
   logic          slip;

   assign tmr_done = (tmr == '0);

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr_done ? '0 : tmr - TW'(1);
      count_nxt = calib_count;
      fail_nxt  = align_fail;
      lost_nxt  = lock_lost;
      slip      = 1'b0;

      case (state)
         S_WAIT_LOCK: begin
            if (!pll_lock) begin
               tmr_nxt = LOCK_LD;
            end else if (tmr_done) begin
               state_nxt = S_DIV_RST;
               tmr_nxt   = RST_LD;
               count_nxt = '0;
               fail_nxt  = 1'b0;
            end
         end
         S_DIV_RST: begin
            if (tmr_done) begin
               state_nxt = S_SETTLE;
               tmr_nxt   = SETTLE_LD;
            end
         end
         S_SETTLE: begin
            if (tmr_done) state_nxt = S_READY;
         end
         S_READY: begin
            if (auto_align) begin
               if (!align_ok) begin
                  if (calib_count < MAXC) slip = 1'b1;
                  else                    fail_nxt = 1'b1;
               end
            end else if (align_req) begin
               slip = 1'b1;
            end
            if (slip) begin
               state_nxt = S_CALIB;
               tmr_nxt   = CALW_LD;
               count_nxt = (calib_count == 4'hf) ? calib_count : calib_count + 4'd1;
            end
         end
         S_CALIB: begin
            if (tmr_done) begin
               state_nxt = S_GAP;
               tmr_nxt   = GAP_LD;
            end
         end
         S_GAP: begin
            if (tmr_done) state_nxt = S_READY;
         end
         default: begin
            state_nxt = S_WAIT_LOCK;
            tmr_nxt   = LOCK_LD;
         end
      endcase

      // Losing lock outranks everything decided above, including a same-cycle slip or fail.
      if (state != S_WAIT_LOCK && !pll_lock) begin
         state_nxt = S_WAIT_LOCK;
         tmr_nxt   = LOCK_LD;
         count_nxt = calib_count;
         fail_nxt  = align_fail;
         if (state == S_READY || state == S_CALIB || state == S_GAP) lost_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_WAIT_LOCK;
         tmr           <= LOCK_LD;
         clkdiv_resetn <= 1'b0;
         clkdiv_calib  <= 1'b0;
         ready         <= 1'b0;
         calib_count   <= '0;
         align_fail    <= 1'b0;
         lock_lost     <= 1'b0;
      end else begin
         state         <= state_nxt;
         tmr           <= tmr_nxt;
         clkdiv_resetn <= (state_nxt == S_SETTLE) || (state_nxt == S_READY) ||
                          (state_nxt == S_CALIB)  || (state_nxt == S_GAP);
         clkdiv_calib  <= (state_nxt == S_CALIB);
         ready         <= (state_nxt == S_READY);
         calib_count   <= count_nxt;
         align_fail    <= fail_nxt;
         lock_lost     <= lost_nxt;
      end
   end

endmodule

// File: tb/tb_clkdiv_init_ctrl.sv
// Bench for clkdiv_init_ctrl: expected slips are queued when stimulus is driven and
// checked by a monitor when each clkdiv_calib pulse ends.
`timescale 1ns/1ps
module tb_clkdiv_init_ctrl;

   logic       clk;
   logic       rst;
   logic       pll_lock;
   logic       auto_align;
   logic       align_req;
   logic       align_ok;
   logic       clkdiv_resetn;
   logic       clkdiv_calib;
   logic       ready;
   logic [3:0] calib_count;
   logic       align_fail;
   logic       lock_lost;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int width;
      int count;
   } slip_t;

   slip_t exp_q[$];
   int    run_len = 0;

   clkdiv_init_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .pll_lock      (pll_lock),
      .auto_align    (auto_align),
      .align_req     (align_req),
      .align_ok      (align_ok),
      .clkdiv_resetn (clkdiv_resetn),
      .clkdiv_calib  (clkdiv_calib),
      .ready         (ready),
      .calib_count   (calib_count),
      .align_fail    (align_fail),
      .lock_lost     (lock_lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp_v, input int tol = 0);
      int diff;
      n_checks++;
      diff = obs - exp_v;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d (tol %0d)", tag, obs, exp_v, tol);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // slip monitor: measures each calib pulse and retires one expected slip
   always @(negedge clk) begin
      if (clkdiv_calib) begin
         run_len++;
      end else if (run_len > 0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_slip_width", run_len, 0);
         end else begin
            slip_t e;
            e = exp_q.pop_front();
            chk("slip_width", run_len, e.width);
            chk("slip_count", int'(calib_count), e.count);
         end
         run_len = 0;
      end
   end

   task automatic do_reset();
      rst       = 1'b1;
      pll_lock  = 1'b0;
      align_req = 1'b0;
      cyc(2);
      chk("rst_resetn", int'(clkdiv_resetn), 0);
      chk("rst_calib",  int'(clkdiv_calib),  0);
      chk("rst_ready",  int'(ready),         0);
      chk("rst_count",  int'(calib_count),   0);
      chk("rst_fail",   int'(align_fail),    0);
      chk("rst_lost",   int'(lock_lost),     0);
      rst = 1'b0;
   endtask

   // cnt = clock edges elapsed since pll_lock was first driven high
   task automatic bring_up(input string tag, input int glitch, input int exp_rn, input int exp_rdy);
      int cnt;
      int t_rn;
      int t_rdy;
      cnt   = 0;
      t_rn  = -1;
      t_rdy = -1;
      pll_lock = 1'b1;
      while (t_rdy < 0 && cnt < 400) begin
         @(negedge clk);
         cnt++;
         pll_lock = (cnt == glitch) ? 1'b0 : 1'b1;
         if (t_rn < 0 && clkdiv_resetn) t_rn = cnt;
         if (ready) t_rdy = cnt;
      end
      chk({tag, "_resetn_cyc"}, t_rn, exp_rn, 1);
      chk({tag, "_ready_cyc"}, t_rdy, exp_rdy, 1);
   endtask

   initial begin
      rst        = 1'b1;
      pll_lock   = 1'b0;
      auto_align = 1'b0;
      align_req  = 1'b0;
      align_ok   = 1'b0;

      // T1: clean bring-up, no slips
      do_reset();
      bring_up("t1", -1, 80, 112);
      cyc(20);
      chk("t1_ready_hold", int'(ready), 1);
      chk("t1_pending", exp_q.size(), 0);

      // T2: one-cycle lock glitch restarts the lock counter
      do_reset();
      bring_up("t2", 40, 121, 153);
      chk("t2_lock_lost", int'(lock_lost), 0);

      // T3: manual slips, a request during GAP is dropped
      cyc(5);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{width: 2, count: i + 1});
         align_req = 1'b1;
         cyc(1);
         align_req = 1'b0;
         if (i == 0) begin
            chk("t3_ready_in_calib", int'(ready), 0);
            chk("t3_calib_high", int'(clkdiv_calib), 1);
         end
         if (i == 2) begin
            cyc(9);
            align_req = 1'b1;
            cyc(1);
            align_req = 1'b0;
            cyc(9);
         end else begin
            cyc(19);
         end
      end
      cyc(20);
      chk("t3_count", int'(calib_count), 3);
      chk("t3_ready", int'(ready), 1);
      chk("t3_pending", exp_q.size(), 0);

      // T4: auto mode, aligner locks after the third slip
      do_reset();
      auto_align = 1'b1;
      align_ok   = 1'b0;
      for (int i = 1; i <= 3; i++) exp_q.push_back('{width: 2, count: i});
      bring_up("t4", -1, 80, 112);
      begin
         int budget;
         budget = 0;
         while (!(calib_count == 4'd3 && !clkdiv_calib) && budget < 200) begin
            cyc(1);
            budget++;
         end
         chk("t4_third_slip_wait", budget < 200 ? 1 : 0, 1);
      end
      align_ok = 1'b1;
      cyc(60);
      chk("t4_count", int'(calib_count), 3);
      chk("t4_ready", int'(ready), 1);
      chk("t4_fail", int'(align_fail), 0);
      chk("t4_pending", exp_q.size(), 0);

      // T5: auto mode, never aligns -> exactly MAX_CALIB slips then align_fail
      do_reset();
      auto_align = 1'b1;
      align_ok   = 1'b0;
      for (int i = 1; i <= 5; i++) exp_q.push_back('{width: 2, count: i});
      bring_up("t5", -1, 80, 112);
      cyc(150);
      chk("t5_fail", int'(align_fail), 1);
      chk("t5_count", int'(calib_count), 5);
      chk("t5_ready", int'(ready), 1);
      chk("t5_calib_low", int'(clkdiv_calib), 0);
      chk("t5_pending", exp_q.size(), 0);

      // T6: lock drops in the first CALIB cycle, pulse truncated
      auto_align = 1'b0;
      align_ok   = 1'b0;
      do_reset();
      bring_up("t6", -1, 80, 112);
      cyc(3);
      exp_q.push_back('{width: 1, count: 1});
      align_req = 1'b1;
      cyc(1);
      align_req = 1'b0;
      pll_lock  = 1'b0;
      cyc(1);
      chk("t6_calib", int'(clkdiv_calib), 0);
      chk("t6_resetn", int'(clkdiv_resetn), 0);
      chk("t6_ready", int'(ready), 0);
      chk("t6_lost", int'(lock_lost), 1);
      bring_up("t6_relock", -1, 80, 112);
      chk("t6_relock_count", int'(calib_count), 0);
      chk("t6_relock_lost", int'(lock_lost), 1);
      chk("t6_pending", exp_q.size(), 0);
      do_reset();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
